traceback_engine: RTL and testbench

//  Reader side of the systolic direction-SRAM store. After a fill completes, walks back from end cell
//  (tb_x,tb_y) through stored 5-bit direction codes and streams alignment ops (end->start order) over a

---
 rtl/traceback_engine_pkg.sv | 52 +++++
 rtl/traceback_engine_dir_unpack.sv | 12 +
 rtl/traceback_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_traceback_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traceback_engine_pkg.sv
// Shared definitions for the direction-RAM traceback reader: code field layout,
// H-source and op encodings, and the lane-extract helper shared with the PE writer.
package traceback_engine_pkg;

  localparam int DIR_W          = 5;
  localparam int CODES_PER_WORD = 16;
  localparam int WORD_W         = DIR_W * CODES_PER_WORD;
  localparam int STEP_W         = 13;

  localparam int SRC_MSB  = 2;
  localparam int SRC_LSB  = 0;
  localparam int HEXT_BIT = 3;
  localparam int VEXT_BIT = 4;

  typedef enum logic [2:0] {
    SRC_STOP  = 3'd0,
    SRC_DIAG  = 3'd1,
    SRC_E     = 3'd2,
    SRC_E_HAT = 3'd3,
    SRC_F     = 3'd4,
    SRC_F_HAT = 3'd5
  } h_src_e;

  typedef enum logic [1:0] {
    OP_M = 2'b00,
    OP_I = 2'b01,
    OP_D = 2'b10
  } op_code_e;

  typedef enum logic [1:0] {
    MODE_H  = 2'd0,
    MODE_HG = 2'd1,
    MODE_VG = 2'd2
  } tb_mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_RESP   = 3'd3,
    S_DECODE = 3'd4,
    S_EMIT   = 3'd5,
    S_DONE   = 3'd6
  } tb_state_e;

  // Lane 0 sits in the most significant code slot of the word.
  function automatic logic [DIR_W-1:0] dir_lane_extract(input logic [WORD_W-1:0] word,
                                                        input logic [3:0]        lane);
    dir_lane_extract = word[(CODES_PER_WORD - int'(lane)) * DIR_W - 1 -: DIR_W];
  endfunction

endpackage

// File: rtl/traceback_engine_dir_unpack.sv
// Combinational unpack of one 5-bit direction code from an 80-bit direction-RAM word.
module traceback_engine_dir_unpack
  import traceback_engine_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [3:0]        lane_i,
  output logic [DIR_W-1:0]  code_o
);

  assign code_o = dir_lane_extract(word_i, lane_i);

endmodule

// File: rtl/traceback_engine.sv
// Walks stored direction codes back from the end cell and streams alignment ops
// (end-to-start order) over a valid/ready port.
module traceback_engine
  import traceback_engine_pkg::*;
#(
  parameter int N             = 64,
  parameter int ADDRESS_WIDTH = 11,
  parameter int MEM_BLK_W     = 6,
  parameter int MAX_STEPS     = 4096
)(
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] tb_x,
  input  logic [ADDRESS_WIDTH-1:0] tb_y,
  output logic [ADDRESS_WIDTH-1:0] column_num,
  output logic [MEM_BLK_W-1:0]     mem_block_num,
  input  logic [WORD_W-1:0]        column_k0,
  input  logic [WORD_W-1:0]        column_k1,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [1:0]               op_code,
  output logic                     op_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [ADDRESS_WIDTH-1:0] ROW_LIMIT = ADDRESS_WIDTH'(N);
  localparam logic [STEP_W-1:0]        STEP_LIMIT = STEP_W'(MAX_STEPS);
  localparam logic [ADDRESS_WIDTH-1:0] ONE_A = ADDRESS_WIDTH'(1);

  tb_state_e                state_q, state_d;
  tb_mode_e                 mode_q, mode_d;
  logic [ADDRESS_WIDTH-1:0] row_q, row_d;
  logic [ADDRESS_WIDTH-1:0] col_q, col_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic [WORD_W-1:0]        word_q, word_d;
  logic [WORD_W-1:0]        k1_q, k1_d;
  logic                     reuse_q, reuse_d;
  logic [ADDRESS_WIDTH-1:0] col_addr_q, col_addr_d;
  logic [MEM_BLK_W-1:0]     blk_addr_q, blk_addr_d;
  logic                     op_valid_q, op_valid_d;
  logic [1:0]               op_code_q, op_code_d;
  logic                     op_last_q, op_last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic [ADDRESS_WIDTH-1:0] row_m1_s;
  logic [DIR_W-1:0]         code_s;
  logic [2:0]               src_s;

  assign row_m1_s = row_q - ONE_A;
  assign src_s    = code_s[SRC_MSB:SRC_LSB];

  traceback_engine_dir_unpack u_unpack (
    .word_i (word_q),
    .lane_i (row_m1_s[3:0]),
    .code_o (code_s)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_H;
      row_q      <= '0;
      col_q      <= '0;
      step_q     <= '0;
      word_q     <= '0;
      k1_q       <= '0;
      reuse_q    <= 1'b0;
      col_addr_q <= '0;
      blk_addr_q <= '0;
      op_valid_q <= 1'b0;
      op_code_q  <= 2'b00;
      op_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      row_q      <= row_d;
      col_q      <= col_d;
      step_q     <= step_d;
      word_q     <= word_d;
      k1_q       <= k1_d;
      reuse_q    <= reuse_d;
      col_addr_q <= col_addr_d;
      blk_addr_q <= blk_addr_d;
      op_valid_q <= op_valid_d;
      op_code_q  <= op_code_d;
      op_last_q  <= op_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Walk FSM: next state, counters, read address and registered op outputs
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    row_d      = row_q;
    col_d      = col_q;
    step_d     = step_q;
    word_d     = word_q;
    k1_d       = k1_q;
    reuse_d    = reuse_q;
    col_addr_d = col_addr_q;
    blk_addr_d = blk_addr_q;
    op_valid_d = op_valid_q;
    op_code_d  = op_code_q;
    op_last_d  = op_last_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = tb_y;
          col_d   = tb_x;
          step_d  = '0;
          mode_d  = MODE_H;
          reuse_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHECK: begin
        if (row_q == '0 || col_q == '0) begin
          state_d = S_DONE;
        end else if (row_q > ROW_LIMIT || step_q == STEP_LIMIT) begin
          // A row beyond the array depth has no stored codes; abort like a runaway walk.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (reuse_q) begin
          word_d  = k1_q;
          reuse_d = 1'b0;
          state_d = S_DECODE;
        end else begin
          col_addr_d = col_q - ONE_A;
          blk_addr_d = MEM_BLK_W'(row_m1_s >> 4);
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_RESP;
      end

      S_RESP: begin
        word_d  = column_k0;
        k1_d    = column_k1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (mode_q)
          MODE_H: begin
            case (src_s)
              SRC_DIAG: begin
                row_d      = row_q - ONE_A;
                col_d      = col_q - ONE_A;
                op_valid_d = 1'b1;
                op_code_d  = OP_M;
                op_last_d  = (row_q == ONE_A) || (col_q == ONE_A);
                state_d    = S_EMIT;
              end
              SRC_E, SRC_E_HAT: begin
                mode_d = MODE_HG;
              end
              SRC_F, SRC_F_HAT: begin
                mode_d = MODE_VG;
              end
              default: begin
                state_d = S_DONE;
              end
            endcase
          end
          MODE_HG: begin
            col_d      = col_q - ONE_A;
            op_valid_d = 1'b1;
            op_code_d  = OP_D;
            op_last_d  = (col_q == ONE_A);
            mode_d     = code_s[HEXT_BIT] ? MODE_HG : MODE_H;
            state_d    = S_EMIT;
          end
          MODE_VG: begin
            // Leaving the top lane of a block: the block below is already in the k1 shadow.
            row_d      = row_q - ONE_A;
            op_valid_d = 1'b1;
            op_code_d  = OP_I;
            op_last_d  = (row_q == ONE_A);
            mode_d     = code_s[VEXT_BIT] ? MODE_VG : MODE_H;
            reuse_d    = (row_q[3:0] == 4'd1);
            state_d    = S_EMIT;
          end
          default: begin
            mode_d  = MODE_H;
            state_d = S_DONE;
          end
        endcase
      end

      S_EMIT: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          op_code_d  = 2'b00;
          op_last_d  = 1'b0;
          step_d     = step_q + STEP_W'(1);
          state_d    = S_CHECK;
        end else begin
          state_d = S_EMIT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign column_num    = col_addr_q;
  assign mem_block_num = blk_addr_q;
  assign op_valid      = op_valid_q;
  assign op_code       = op_code_q;
  assign op_last       = op_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_traceback_engine.sv
// Scoreboard bench for traceback_engine: a registered direction-RAM model serves
// reads, expected ops are queued at start and compared as the DUT hands them over.
module tb_traceback_engine;
  import traceback_engine_pkg::*;

  localparam int AW = 11;
  localparam int BW = 6;
  localparam logic [4:0] C_DIAG = 5'b00001;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          start;
  logic [AW-1:0] tb_x, tb_y;
  logic [AW-1:0] column_num;
  logic [BW-1:0] mem_block_num;
  logic [79:0]   column_k0, column_k1;
  logic          op_valid, op_ready, op_last, busy, done, err;
  logic [1:0]    op_code;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]    code;
    logic          last;
    logic [AW-1:0] colnum;
    logic [BW-1:0] blk;
  } op_t;

  op_t        exp_q[$];
  op_t        obs_q[$];
  logic [4:0] code_mem [0:80][0:31];

  always #5 clk = ~clk;

  traceback_engine #(.MAX_STEPS(8)) dut (
    .clk(clk), .reset_i(reset_i), .start(start), .tb_x(tb_x), .tb_y(tb_y),
    .column_num(column_num), .mem_block_num(mem_block_num),
    .column_k0(column_k0), .column_k1(column_k1),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_last(op_last),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [79:0] pack_word(input int col, input int blk);
    logic [79:0] w;
    w = '0;
    for (int p = 0; p < 16; p++) begin
      int r;
      r = blk * 16 + p + 1;
      if (r <= 80 && col <= 31) w[(16 - p) * 5 - 1 -: 5] = code_mem[r][col];
    end
    return w;
  endfunction

  // Direction RAM: data for the presented address appears one cycle later
  always @(posedge clk) begin
    column_k0 <= pack_word(int'(column_num) + 1, int'(mem_block_num));
    column_k1 <= (mem_block_num == '0) ? 80'd0
                 : pack_word(int'(column_num) + 1, int'(mem_block_num) - 1);
  end

  task automatic clear_mem();
    for (int r = 0; r <= 80; r++)
      for (int c = 0; c <= 31; c++) code_mem[r][c] = 5'd0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic push_exp(input logic [1:0] code, input logic last, input int colnum, input int blk);
    op_t e;
    e.code = code; e.last = last; e.colnum = AW'(colnum); e.blk = BW'(blk);
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int x, input int y);
    @(negedge clk);
    tb_x = AW'(x); tb_y = AW'(y); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic record_op();
    op_t o;
    o.code = op_code; o.last = op_last; o.colnum = column_num; o.blk = mem_block_num;
    obs_q.push_back(o);
  endtask

  task automatic collect(input int budget, output bit done_seen, output bit err_at_done);
    done_seen = 1'b0;
    err_at_done = 1'b0;
    for (int i = 0; i < budget && !done_seen; i++) begin
      @(negedge clk);
      if (op_valid && op_ready) record_op();
      if (done) begin done_seen = 1'b1; err_at_done = err; end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start = 1'b0; op_ready = 1'b0; tb_x = '0; tb_y = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({op_valid, op_code, op_last, busy, done, err, column_num, mem_block_num} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b c=%b l=%b busy=%b done=%b err=%b col=%0d blk=%0d required all 0",
               op_valid, op_code, op_last, busy, done, err, column_num, mem_block_num);
    end
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({op_valid, busy, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got v=%b busy=%b done=%b err=%b required 0", op_valid, busy, done, err);
    end
  endtask

  task automatic test_empty();
    clear_mem();
    op_ready = 1'b1;
    pulse_start(0, 5);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL empty_busy: got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b required 1", done); end
    checks++;
    if (err !== 1'b0 || op_valid !== 1'b0) begin
      errors++; $display("FAIL empty_noop: got err=%b op_valid=%b required 0 0", err, op_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL empty_pulse: got done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_diag();
    op_t e, o; bit ds, de;
    clear_mem();
    for (int r = 1; r <= 3; r++) for (int c = 1; c <= 3; c++) code_mem[r][c] = C_DIAG;
    for (int k = 0; k < 3; k++) push_exp(OP_M, k == 2, 2 - k, 0);
    op_ready = 1'b1;
    pulse_start(3, 3);
    collect(200, ds, de);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL diag_op: got %h required %h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL diag_extra: got %0d extra ops required 0", obs_q.size()); end
    checks++;
    if (!ds || de) begin errors++; $display("FAIL diag_done: got done=%b err=%b required 1 0", ds, de); end
  endtask

  task automatic test_vgap();
    op_t e, o; bit ds, de;
    clear_mem();
    for (int r = 17; r <= 20; r++) code_mem[r][4] = 5'b10100;
    code_mem[16][4] = 5'b00100;
    code_mem[15][4] = 5'b00000;
    for (int k = 0; k < 5; k++) push_exp(OP_I, 1'b0, 3, 1);
    op_ready = 1'b1;
    pulse_start(4, 20);
    collect(200, ds, de);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL vgap_op: got %h required %h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL vgap_extra: got %0d extra ops required 0", obs_q.size()); end
    checks++;
    if (!ds || de) begin errors++; $display("FAIL vgap_done: got done=%b err=%b required 1 0", ds, de); end
  endtask

  task automatic test_hgap();
    op_t e, o; bit ds, de;
    clear_mem();
    code_mem[5][9] = 5'b01011;
    code_mem[5][8] = 5'b01000;
    code_mem[5][7] = 5'b00000;
    for (int k = 0; k < 3; k++) push_exp(OP_D, 1'b0, 8 - k, 0);
    op_ready = 1'b1;
    pulse_start(9, 5);
    collect(200, ds, de);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL hgap_op: got %h required %h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL hgap_extra: got %0d extra ops required 0", obs_q.size()); end
    checks++;
    if (!ds || de) begin errors++; $display("FAIL hgap_done: got done=%b err=%b required 1 0", ds, de); end
  endtask

  task automatic test_backpressure();
    op_t e, o; bit ds, de; int n;
    clear_mem();
    for (int r = 1; r <= 4; r++) for (int c = 1; c <= 4; c++) code_mem[r][c] = C_DIAG;
    for (int k = 0; k < 4; k++) push_exp(OP_M, k == 3, 3 - k, 0);
    op_ready = 1'b1;
    pulse_start(4, 4);
    n = 0;
    while (obs_q.size() == 0 && n < 50) begin
      @(negedge clk); n++;
      if (op_valid && op_ready) record_op();
    end
    @(posedge clk); #1 op_ready = 1'b0;
    n = 0;
    while (!op_valid && n < 20) begin @(negedge clk); n++; end
    e = exp_q[1];
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (op_valid !== 1'b1 || op_code !== e.code || op_last !== e.last || column_num !== e.colnum) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got v=%b c=%b l=%b col=%0d required 1 %b %b %0d",
                 i, op_valid, op_code, op_last, column_num, e.code, e.last, e.colnum);
      end
      if (i == 3) begin tb_x = '0; tb_y = '0; start = 1'b1; end
      else if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    op_ready = 1'b1;
    if (op_valid) record_op();
    collect(200, ds, de);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL stall_op: got %h required %h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL stall_extra: got %0d extra ops required 0", obs_q.size()); end
    checks++;
    if (!ds || de) begin errors++; $display("FAIL stall_done: got done=%b err=%b required 1 0", ds, de); end
  endtask

  task automatic test_reset_midwalk();
    clear_mem();
    for (int r = 1; r <= 3; r++) for (int c = 1; c <= 3; c++) code_mem[r][c] = C_DIAG;
    op_ready = 1'b0;
    pulse_start(3, 3);
    repeat (6) @(negedge clk);
    reset_i = 1'b1;
    #1;
    checks++;
    if ({op_valid, op_code, op_last, busy, done, err, column_num, mem_block_num} !== '0) begin
      errors++;
      $display("FAIL reset_midwalk: got v=%b c=%b l=%b busy=%b done=%b err=%b col=%0d blk=%0d required all 0",
               op_valid, op_code, op_last, busy, done, err, column_num, mem_block_num);
    end
    @(negedge clk);
    reset_i = 1'b0;
    op_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_abort: cycle %0d got done=%b busy=%b required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_max_steps();
    op_t e, o; bit ds, de;
    clear_mem();
    for (int r = 1; r <= 20; r++) for (int c = 1; c <= 20; c++) code_mem[r][c] = C_DIAG;
    for (int k = 0; k < 8; k++) push_exp(OP_M, 1'b0, 19 - k, (19 - k) >> 4);
    op_ready = 1'b1;
    pulse_start(20, 20);
    collect(300, ds, de);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL limit_op: got %h required %h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL limit_extra: got %0d extra ops required 0", obs_q.size()); end
    checks++;
    if (!ds || !de) begin errors++; $display("FAIL limit_done: got done=%b err=%b required 1 1", ds, de); end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end
    pulse_start(0, 5);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", err); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_diag();
    test_vgap();
    test_hgap();
    test_backpressure();
    test_reset_midwalk();
    test_max_steps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
